// File: rtl/crm_wcs_pkg.sv
// crm_wcs shared types
// FSM states and chunk-count helper for the writable control store
package crm_wcs_pkg;

  typedef enum logic [2:0] {
    CRM_IDLE,
    CRM_COLLECT,
    CRM_COMMIT,
    CRM_FETCH,
    CRM_RDOUT
  } crm_wcs_state_t;

  function automatic int crm_nchunk(
    input int width,
    input int chunk_w
  );
    return (width + chunk_w - 1) / chunk_w;
  endfunction

endpackage

// File: rtl/crm_wcs_ram.sv
// crm_wcs_ram: control store array, diag r/w port A + microword read port B
// Both read ports are registered and read-first; port B output is resettable
module crm_wcs_ram #(
  parameter int DEPTH = 2048,
  parameter int DW    = 85,
  parameter int WW    = 84,
  parameter int AW    = 11,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] adra,
  input  logic [DW-1:0] da,
  output logic [WW-1:0] qa,
  input  logic [AW-1:0] adrb,
  output logic [DW-1:0] qb
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[adra] <= da;
    qa <= mem[adra][DW-1 -: WW];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) qb <= RST_VAL;
    else     qb <= mem[adrb];
  end

endmodule

// File: rtl/crm_wcs.sv
// crm_wcs: writable control store with chunked diagnostic load/readback
// Owns the diag FSM, assembly register and odd-parity generate/check
module crm_wcs #(
  parameter int DEPTH   = 2048,
  parameter int WIDTH   = 84,
  parameter int CHUNK_W = 12,
  parameter int PARITY  = 1,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  cradr,
  output logic [WIDTH-1:0]   cram_data,
  output logic               crm_par_err,
  input  logic               diag_adr_ld,
  input  logic [ADDR_W-1:0]  diag_adr,
  input  logic               diag_wr,
  input  logic [CHUNK_W-1:0] diag_din,
  input  logic               diag_rd,
  input  logic               diag_next,
  output logic [CHUNK_W-1:0] diag_dout,
  output logic               diag_busy,
  output logic               diag_done,
  output logic               diag_ovr
);

  import crm_wcs_pkg::*;

  localparam int NCHUNK = crm_nchunk(WIDTH, CHUNK_W);
  localparam int ASM_W  = NCHUNK * CHUNK_W;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int DW     = WIDTH + ((PARITY != 0) ? 1 : 0);
  localparam logic [CW-1:0]     LAST = CW'(NCHUNK - 1);
  localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(DEPTH - 1);

  crm_wcs_state_t state, state_n;

  logic [ADDR_W-1:0] adr;
  logic [CW-1:0]     cnt;
  logic [ASM_W-1:0]  asm_q;
  logic [ASM_W-1:0]  fetch_w;
  logic [ASM_W-1:0]  shifted;
  logic [WIDTH-1:0]  word;
  logic [WIDTH-1:0]  qa;
  logic [DW-1:0]     wd;
  logic [DW-1:0]     qb;

  logic last, we, strobe;
  logic put, ld_asm, inc_cnt, clr_cnt;
  logic inc_adr, set_ovr, done_n;

  assign last   = (cnt == LAST);
  assign strobe = diag_wr | diag_rd | diag_next;
  // write enable follows the state register so an async reset kills it
  assign we     = (state == CRM_COMMIT);
  assign word   = asm_q[ASM_W-1 -: WIDTH];

  assign diag_busy = (state == CRM_COMMIT) || (state == CRM_FETCH);

  assign shifted   = asm_q << (int'(cnt) * CHUNK_W);
  assign diag_dout = (state == CRM_RDOUT)
                   ? shifted[ASM_W-1 -: CHUNK_W] : '0;

  always_comb begin
    fetch_w = '0;
    fetch_w[ASM_W-1 -: WIDTH] = qa;
  end

  assign cram_data = qb[DW-1 -: WIDTH];

  if (PARITY != 0) begin : g_par
    assign wd          = {word, ~^word};
    assign crm_par_err = ~^qb;
  end else begin : g_nopar
    assign wd          = word;
    assign crm_par_err = 1'b0;
  end

  // reset value carries a good parity bit so the idle output reads clean
  crm_wcs_ram #(
    .DEPTH   (DEPTH),
    .DW      (DW),
    .WW      (WIDTH),
    .AW      (ADDR_W),
    .RST_VAL (DW'(PARITY != 0))
  ) u_ram (
    .clk  (clk),
    .rst  (reset),
    .we   (we),
    .adra (adr),
    .da   (wd),
    .qa   (qa),
    .adrb (cradr),
    .qb   (qb)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CRM_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (diag_adr_ld) begin
      state_n = CRM_COLLECT;
    end else begin
      unique case (state)
        CRM_COLLECT: begin
          if (diag_wr) begin
            if (last) state_n = CRM_COMMIT;
          end else if (diag_rd && cnt == '0) begin
            state_n = CRM_FETCH;
          end
        end
        CRM_COMMIT: state_n = CRM_COLLECT;
        CRM_FETCH:  state_n = CRM_RDOUT;
        CRM_RDOUT: begin
          if (diag_next && last) state_n = CRM_COLLECT;
        end
        default: state_n = state;
      endcase
    end
  end

  always_comb begin
    put     = 1'b0;
    ld_asm  = 1'b0;
    inc_cnt = 1'b0;
    clr_cnt = 1'b0;
    inc_adr = 1'b0;
    set_ovr = 1'b0;
    done_n  = 1'b0;
    if (!diag_adr_ld) begin
      unique case (state)
        CRM_COLLECT: begin
          if (diag_wr) begin
            put     = 1'b1;
            inc_cnt = !last;
            set_ovr = diag_rd | diag_next;
          end else if (diag_rd) begin
            set_ovr = (cnt != '0) | diag_next;
          end else begin
            set_ovr = diag_next;
          end
        end
        CRM_COMMIT: begin
          inc_adr = 1'b1;
          clr_cnt = 1'b1;
          done_n  = 1'b1;
          set_ovr = strobe;
        end
        CRM_FETCH: begin
          ld_asm  = 1'b1;
          clr_cnt = 1'b1;
          set_ovr = strobe;
        end
        CRM_RDOUT: begin
          set_ovr = diag_wr | diag_rd;
          if (diag_next) begin
            if (last) begin
              inc_adr = 1'b1;
              clr_cnt = 1'b1;
              done_n  = 1'b1;
            end else begin
              inc_cnt = 1'b1;
            end
          end
        end
        default: set_ovr = strobe;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adr       <= '0;
      cnt       <= '0;
      asm_q     <= '0;
      diag_ovr  <= 1'b0;
      diag_done <= 1'b0;
    end else begin
      diag_done <= done_n;
      if (diag_adr_ld) begin
        adr      <= diag_adr;
        cnt      <= '0;
        diag_ovr <= 1'b0;
      end else begin
        if (inc_adr) adr <= (adr == TOP) ? '0 : adr + 1'b1;
        if (clr_cnt)      cnt <= '0;
        else if (inc_cnt) cnt <= cnt + 1'b1;
        if (set_ovr) diag_ovr <= 1'b1;
      end
      if (put)
        asm_q[ASM_W-1 - int'(cnt) * CHUNK_W -: CHUNK_W] <= diag_din;
      if (ld_asm) asm_q <= fetch_w;
    end
  end

endmodule

// File: tb/tb_crm_wcs.sv
// tb_crm_wcs: randomized diag load/readback against a word-level model
// Model keeps written words in an associative array keyed by address
module tb_crm_wcs;

  localparam int DEPTH = 2048;
  localparam int WIDTH = 84;
  localparam int CW    = 12;
  localparam int NCH   = 7;
  localparam int AW    = 11;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [AW-1:0]   cradr = '0;
  logic [WIDTH-1:0] cram_data;
  logic            crm_par_err;
  logic            diag_adr_ld = 1'b0;
  logic [AW-1:0]   diag_adr = '0;
  logic            diag_wr = 1'b0;
  logic [CW-1:0]   diag_din = '0;
  logic            diag_rd = 1'b0;
  logic            diag_next = 1'b0;
  logic [CW-1:0]   diag_dout;
  logic            diag_busy;
  logic            diag_done;
  logic            diag_ovr;

  always #5 clk = ~clk;

  crm_wcs #(
    .DEPTH(DEPTH), .WIDTH(WIDTH), .CHUNK_W(CW), .PARITY(1)
  ) dut (
    .clk(clk), .reset(reset), .cradr(cradr),
    .cram_data(cram_data), .crm_par_err(crm_par_err),
    .diag_adr_ld(diag_adr_ld), .diag_adr(diag_adr),
    .diag_wr(diag_wr), .diag_din(diag_din),
    .diag_rd(diag_rd), .diag_next(diag_next),
    .diag_dout(diag_dout), .diag_busy(diag_busy),
    .diag_done(diag_done), .diag_ovr(diag_ovr)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [WIDTH-1:0] ref_mem [int];
  int ref_adr = 0;
  bit ref_ovr = 1'b0;

  task automatic check(input string tag,
                       input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic logic [CW-1:0] chunk_of(
    input logic [WIDTH-1:0] w, input int c);
    logic [NCH*CW-1:0] p;
    p = (NCH*CW)'(w) << (NCH*CW - WIDTH);
    return CW'(p >> ((NCH - 1 - c) * CW));
  endfunction

  function automatic bit par_of(input logic [WIDTH-1:0] w);
    return ($countones(w) % 2) == 0;
  endfunction

  function automatic bit exp_perr(input logic [WIDTH-1:0] w,
                                  input bit par);
    return (($countones(w) + int'(par)) % 2) == 0;
  endfunction

  function automatic logic [WIDTH-1:0] rnd_word();
    return WIDTH'({$urandom, $urandom, $urandom});
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_adr(input int a);
    diag_adr_ld = 1'b1;
    diag_adr = AW'(a);
    tick();
    diag_adr_ld = 1'b0;
    ref_adr = a;
    ref_ovr = 1'b0;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] w,
                            input bit poke, input string tag);
    for (int c = 0; c < NCH; c++) begin
      diag_wr = 1'b1;
      diag_din = chunk_of(w, c);
      tick();
    end
    diag_wr = 1'b0;
    check({tag, ".busy"}, diag_busy, 1'b1);
    if (poke) begin
      diag_wr = 1'b1;
      diag_din = CW'($urandom);
      ref_ovr = 1'b1;
    end
    tick();
    diag_wr = 1'b0;
    check({tag, ".done"}, diag_done, 1'b1);
    check({tag, ".ovr"}, diag_ovr, ref_ovr);
    ref_mem[ref_adr] = w;
    ref_adr = (ref_adr + 1) % DEPTH;
  endtask

  task automatic cram_read(input int a, input string tag);
    cradr = AW'(a);
    tick();
    check({tag, ".data"}, cram_data, ref_mem[a]);
    check({tag, ".perr"}, crm_par_err, 1'b0);
  endtask

  task automatic read_back(input string tag);
    logic [WIDTH-1:0] w;
    w = ref_mem[ref_adr];
    diag_rd = 1'b1;
    tick();
    diag_rd = 1'b0;
    check({tag, ".fbusy"}, diag_busy, 1'b1);
    tick();
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("%s.dout%0d", tag, c), diag_dout, chunk_of(w, c));
      diag_next = 1'b1;
      tick();
      diag_next = 1'b0;
    end
    check({tag, ".rdone"}, diag_done, 1'b1);
    ref_adr = (ref_adr + 1) % DEPTH;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] w, w1, old;
    int a, n;

    tick();
    tick();
    check("rst.data", cram_data, '0);
    check("rst.perr", crm_par_err, 1'b0);
    check("rst.dout", diag_dout, '0);
    check("rst.busy", diag_busy, 1'b0);
    check("rst.done", diag_done, 1'b0);
    check("rst.ovr", diag_ovr, 1'b0);
    reset = 1'b0;
    tick();

    diag_wr = 1'b1;
    tick();
    diag_wr = 1'b0;
    check("idle_wr.ovr", diag_ovr, 1'b1);

    load_adr(5);
    check("ld.ovr", diag_ovr, 1'b0);
    w = '0;
    for (int c = 0; c < NCH; c++)
      w = (w << CW) | WIDTH'(12'h123 + c);
    write_word(w, 1'b0, "t2");
    tick();
    check("t2.done1", diag_done, 1'b0);
    cram_read(5, "t2");
    write_word(rnd_word(), 1'b0, "t2b");
    cram_read(6, "t2b");

    load_adr(DEPTH - 1);
    write_word(rnd_word(), 1'b0, "t3a");
    write_word(rnd_word(), 1'b0, "t3b");
    cram_read(DEPTH - 1, "t3a");
    cram_read(0, "t3wrap");
    load_adr(DEPTH - 1);
    read_back("t3rb0");
    read_back("t3rb1");
    check("t3.ovr", diag_ovr, 1'b0);

    load_adr(16);
    write_word(rnd_word(), 1'b0, "t4a");
    cradr = AW'(16);
    load_adr(16);
    old = ref_mem[16];
    w = rnd_word();
    write_word(w, 1'b0, "t4b");
    check("t4.old", cram_data, old);
    tick();
    check("t4.new", cram_data, w);

    load_adr(64);
    write_word(rnd_word(), 1'b1, "t5poke");
    load_adr(65);
    check("t5.clr", diag_ovr, 1'b0);
    diag_wr = 1'b1;
    diag_rd = 1'b1;
    diag_din = CW'($urandom);
    tick();
    diag_wr = 1'b0;
    diag_rd = 1'b0;
    check("t5.wrrd", diag_ovr, 1'b1);
    check("t5.nofetch", diag_busy, 1'b0);
    load_adr(65);
    check("t5.clr2", diag_ovr, 1'b0);

    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 3);
      load_adr(a);
      for (int k = 0; k < n; k++)
        write_word(rnd_word(), 1'b0, $sformatf("r%0d.w%0d", i, k));
      for (int k = 0; k < n; k++)
        cram_read((a + k) % DEPTH, $sformatf("r%0d.c%0d", i, k));
      load_adr(a);
      for (int k = 0; k < n; k++)
        read_back($sformatf("r%0d.b%0d", i, k));
    end

    load_adr(32);
    w = rnd_word();
    write_word(w, 1'b0, "t6p");
    dut.u_ram.mem[32] = dut.u_ram.mem[32] ^ 85'd1;
    cradr = AW'(32);
    tick();
    check("t6.pdata", cram_data, w);
    check("t6.perr", crm_par_err, exp_perr(w, ~par_of(w)));
    dut.u_ram.mem[32] = dut.u_ram.mem[32] ^ 85'd1;
    tick();
    check("t6.pok", crm_par_err, exp_perr(w, par_of(w)));

    load_adr(48);
    w1 = rnd_word();
    write_word(w1, 1'b0, "t6r");
    load_adr(48);
    w = ~w1;
    for (int c = 0; c < NCH; c++) begin
      diag_wr = 1'b1;
      diag_din = chunk_of(w, c);
      tick();
    end
    diag_wr = 1'b0;
    check("t6.cbusy", diag_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ref_adr = 0;
    ref_ovr = 1'b0;
    cradr = AW'(48);
    tick();
    check("t6.keep", cram_data, w1);
    check("t6.kperr", crm_par_err, 1'b0);
    check("t6.rbusy", diag_busy, 1'b0);
    check("t6.rdone", diag_done, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
